// File: rtl/ecpu_pkg.sv
// Shared definitions for the ecpu front end: default widths, the fixed
// 37-bit instruction field layout, the fetch FSM state encoding and the
// opcode values used by fetch, decode and execute.
package ecpu_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INSTR_W = 37;

  // Instruction field positions (MSB..LSB)
  localparam int IMM_SEL_BIT = 36;
  localparam int OPC_HI      = 35;
  localparam int OPC_LO      = 31;
  localparam int DST_HI      = 30;
  localparam int DST_LO      = 28;
  localparam int SRC_HI      = 27;
  localparam int SRC_LO      = 25;
  localparam int FLAG_BIT    = 24;
  localparam int IMM_HI      = 23;
  localparam int IMM_LO      = 0;

  typedef enum logic [1:0] {
    START = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  // Opcodes shared with decode/execute
  localparam logic [4:0] OPC_NOP  = 5'h00;
  localparam logic [4:0] OPC_LDI  = 5'h01;
  localparam logic [4:0] OPC_MOV  = 5'h02;
  localparam logic [4:0] OPC_ADD  = 5'h03;
  localparam logic [4:0] OPC_SUB  = 5'h04;
  localparam logic [4:0] OPC_AND  = 5'h05;
  localparam logic [4:0] OPC_OR   = 5'h06;
  localparam logic [4:0] OPC_XOR  = 5'h07;
  localparam logic [4:0] OPC_JMP  = 5'h10;
  localparam logic [4:0] OPC_JZ   = 5'h11;
  localparam logic [4:0] OPC_EXIT = 5'h1F;

endpackage

// File: rtl/ecpu_instr_split.sv
// Purpose : combinational split of an instruction word into its fields.
// Latency : 0 cycles (pure wiring). Backpressure: none, no state.
// Ports   : i_ir word in; o_imm_sel/o_opcode/o_dst/o_src/o_flag/o_imm fields out.
module ecpu_instr_split
  import ecpu_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic [INSTR_W-1:0] i_ir,
  output logic               o_imm_sel,
  output logic [4:0]         o_opcode,
  output logic [2:0]         o_dst,
  output logic [2:0]         o_src,
  output logic               o_flag,
  output logic [23:0]        o_imm
);

  assign o_imm_sel = i_ir[IMM_SEL_BIT];
  assign o_opcode  = i_ir[OPC_HI:OPC_LO];
  assign o_dst     = i_ir[DST_HI:DST_LO];
  assign o_src     = i_ir[SRC_HI:SRC_LO];
  assign o_flag    = i_ir[FLAG_BIT];
  assign o_imm     = i_ir[IMM_HI:IMM_LO];

endmodule

// File: rtl/ecpu_fetch.sv
// Purpose : instruction fetch - owns PC, drives ROM address, latches IR and
//           presents split fields to execute; handles jump, stall and halt.
// Latency : first IR valid 2 edges after reset release, then 1/cycle; a jump
//           target is valid 1 edge after the jump edge.
// Backpressure: out_valid/out_ready; a stalled IR holds IR, out_pc and pc.
// Ports   : clk, rst (async active-high); rom_addr/rom_data ROM side;
//           jmp_en/jmp_addr/halt_req from execute; out_* IR fields + out_pc
//           with out_valid/out_ready; halted status.
// Option  : define ECPU_FETCH_CNT_EN to add fetch_cnt[31:0], a wrapping
//           count of accepted transfers.
module ecpu_fetch
  import ecpu_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               jmp_en,
  input  logic [ADDR_W-1:0]  jmp_addr,
  input  logic               halt_req,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_imm_sel,
  output logic [4:0]         out_opcode,
  output logic [2:0]         out_dst,
  output logic [2:0]         out_src,
  output logic               out_flag,
  output logic [23:0]        out_imm,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted
`ifdef ECPU_FETCH_CNT_EN
  ,
  output logic [31:0]        fetch_cnt
`endif
);

  fetch_state_t        r_state;
  fetch_state_t        w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [INSTR_W-1:0]  r_ir;
  logic [ADDR_W-1:0]   r_out_pc;
  logic                r_valid;
  logic                r_halted;
  logic                w_jmp;
  logic                w_load;
  logic                w_xfer;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= START;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; a jump always lands in RUN, even from HALT
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      START:   w_state_nxt = RUN;
      RUN:     if (!jmp_en && halt_req) w_state_nxt = HALT;
      HALT:    if (jmp_en) w_state_nxt = RUN;
      default: w_state_nxt = START;
    endcase
  end

  // Control decode. Jump is ignored in START; load needs a free or
  // draining IR slot and no redirect/halt this cycle.
  always_comb begin
    w_jmp  = jmp_en && (r_state != START);
    w_load = (r_state == RUN) && !jmp_en && !halt_req && (!r_valid || out_ready);
    w_xfer = r_valid && out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_out_pc <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_halted <= (w_state_nxt == HALT);
      if (w_jmp) begin
        // Redirect flushes the IR even if execute is stalling it
        r_pc    <= jmp_addr;
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_ir     <= rom_data;
        r_out_pc <= r_pc;
        r_valid  <= 1'b1;
        r_pc     <= r_pc + 1'b1;  // wraps modulo 2^ADDR_W
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef ECPU_FETCH_CNT_EN
  logic [31:0] r_fetch_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_fetch_cnt <= '0;
    else if (w_xfer) r_fetch_cnt <= r_fetch_cnt + 32'd1;
  end

  assign fetch_cnt = r_fetch_cnt;
`endif

  assign rom_addr  = r_pc;
  assign out_valid = r_valid;
  assign out_pc    = r_out_pc;
  assign halted    = r_halted;

  ecpu_instr_split #(
    .INSTR_W (INSTR_W)
  ) u_split (
    .i_ir      (r_ir),
    .o_imm_sel (out_imm_sel),
    .o_opcode  (out_opcode),
    .o_dst     (out_dst),
    .o_src     (out_src),
    .o_flag    (out_flag),
    .o_imm     (out_imm)
  );

endmodule

// File: tb/tb_ecpu_fetch.sv
// Directed bench for ecpu_fetch: ROM model, reset, streaming, stall,
// jump flush, PC wrap, halt/resume, jump-vs-halt priority, async reset.
module tb_ecpu_fetch;

  logic        clk;
  logic        rst;
  logic [7:0]  rom_addr;
  logic [36:0] rom_data;
  logic        jmp_en;
  logic [7:0]  jmp_addr;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic        out_imm_sel;
  logic [4:0]  out_opcode;
  logic [2:0]  out_dst;
  logic [2:0]  out_src;
  logic        out_flag;
  logic [23:0] out_imm;
  logic [7:0]  out_pc;
  logic        halted;
`ifdef ECPU_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  logic [36:0] rom [256];
  assign rom_data = rom[rom_addr];

  int n_assert = 0;
  int n_fail   = 0;

  ecpu_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .jmp_en      (jmp_en),
    .jmp_addr    (jmp_addr),
    .halt_req    (halt_req),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm_sel (out_imm_sel),
    .out_opcode  (out_opcode),
    .out_dst     (out_dst),
    .out_src     (out_src),
    .out_flag    (out_flag),
    .out_imm     (out_imm),
    .out_pc      (out_pc),
    .halted      (halted)
`ifdef ECPU_FETCH_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ROM word for address a: {a[0], a[4:0], a[7:5], a[2:0], a[7], 16'hC0DE, a}
    for (int a = 0; a < 256; a++) begin
      logic [7:0] av;
      av = 8'(a);
      rom[a] = {av[0], av[4:0], av[7:5], av[2:0], av[7], 16'hC0DE, av};
    end
    rom[0] = {1'b1, 5'd1, 3'd0, 3'd0, 1'b0, 24'h000041};

    rst = 1'b1; jmp_en = 1'b0; jmp_addr = 8'h00; halt_req = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_valid",  out_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_addr",   rom_addr, 8'h00);
    chk("rst_outpc",  out_pc, 8'h00);
    chk("rst_opcode", out_opcode, 0);
    chk("rst_imm",    out_imm, 0);
    tick();
    rst = 1'b0;

    // Edge 1: START -> RUN, nothing fetched
    tick();
    chk("e1_valid", out_valid, 0);
    chk("e1_addr",  rom_addr, 8'h00);
    // Edge 2: first instruction
    tick();
    chk("e2_valid",   out_valid, 1);
    chk("e2_opcode",  out_opcode, 5'd1);
    chk("e2_imm",     out_imm, 24'h000041);
    chk("e2_immsel",  out_imm_sel, 1);
    chk("e2_outpc",   out_pc, 8'h00);
    chk("e2_addr",    rom_addr, 8'h01);

    // Streaming
    tick(); chk("s1_outpc", out_pc, 8'h01);
    tick(); chk("s2_outpc", out_pc, 8'h02);
    tick(); chk("s3_outpc", out_pc, 8'h03);
    tick(); chk("s4_outpc", out_pc, 8'h04);
    chk("s4_addr", rom_addr, 8'h05);
    chk("s4_dst", out_dst, 3'd0);
    chk("s4_src", out_src, 3'd4);

    // Stall for 3 cycles
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_outpc", out_pc, 8'h04);
      chk("stall_addr",  rom_addr, 8'h05);
    end

    // Jump while stalled: flush then fetch target
    jmp_en = 1'b1; jmp_addr = 8'h80;
    tick();
    chk("jmp_valid", out_valid, 0);
    chk("jmp_addr",  rom_addr, 8'h80);
    jmp_en = 1'b0; out_ready = 1'b1;
    tick();
    chk("jt_valid",  out_valid, 1);
    chk("jt_outpc",  out_pc, 8'h80);
    chk("jt_dst",    out_dst, 3'd4);
    chk("jt_flag",   out_flag, 1);
    chk("jt_imm",    out_imm, 24'hC0DE80);
    chk("jt_addr",   rom_addr, 8'h81);

    // PC wrap at 0xFF
    jmp_en = 1'b1; jmp_addr = 8'hFF;
    tick();
    chk("w_addr", rom_addr, 8'hFF);
    jmp_en = 1'b0;
    tick();
    chk("w_outpc",  out_pc, 8'hFF);
    chk("w_opcode", out_opcode, 5'h1F);
    chk("w_addr0",  rom_addr, 8'h00);
    tick();
    chk("w2_outpc", out_pc, 8'h00);
    chk("w2_addr",  rom_addr, 8'h01);

    // Halt with a stalled valid IR
    out_ready = 1'b0; halt_req = 1'b1;
    tick();
    chk("h_halted", halted, 1);
    chk("h_valid",  out_valid, 1);
    chk("h_outpc",  out_pc, 8'h00);
    chk("h_addr",   rom_addr, 8'h01);
    halt_req = 1'b0;
    tick();
    chk("h2_halted", halted, 1);
    chk("h2_valid",  out_valid, 1);
    out_ready = 1'b1;
    tick();
    chk("h3_valid", out_valid, 0);
    tick();
    chk("h4_valid",  out_valid, 0);
    chk("h4_halted", halted, 1);
    chk("h4_addr",   rom_addr, 8'h01);
    jmp_en = 1'b1; jmp_addr = 8'h10;
    tick();
    chk("r_halted", halted, 0);
    chk("r_addr",   rom_addr, 8'h10);
    chk("r_valid",  out_valid, 0);
    jmp_en = 1'b0;
    tick();
    chk("r2_valid",  out_valid, 1);
    chk("r2_outpc",  out_pc, 8'h10);
    chk("r2_opcode", out_opcode, 5'h10);
    chk("r2_addr",   rom_addr, 8'h11);

    // Jump and halt together: jump wins, stays in RUN
    jmp_en = 1'b1; halt_req = 1'b1; jmp_addr = 8'h20;
    tick();
    chk("jh_halted", halted, 0);
    chk("jh_addr",   rom_addr, 8'h20);
    chk("jh_valid",  out_valid, 0);
    jmp_en = 1'b0; halt_req = 1'b0;
    tick();
    chk("jh2_outpc", out_pc, 8'h20);
    chk("jh2_valid", out_valid, 1);

    // Asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    chk("ar_valid",  out_valid, 0);
    chk("ar_halted", halted, 0);
    chk("ar_addr",   rom_addr, 8'h00);
    chk("ar_outpc",  out_pc, 8'h00);
`ifdef ECPU_FETCH_CNT_EN
    chk("ar_cnt", fetch_cnt, 0);
`endif

    // Jump during START is ignored
    jmp_en = 1'b1; jmp_addr = 8'h33;
    tick();
    rst = 1'b0;
    tick();
    chk("st_addr",  rom_addr, 8'h00);
    chk("st_valid", out_valid, 0);
    jmp_en = 1'b0; out_ready = 1'b1;
    tick();
    chk("st2_outpc", out_pc, 8'h00);
    chk("st2_valid", out_valid, 1);

    // 10 transfers, 2 stall cycles, 1 flushed IR
    repeat (10) tick();
    chk("c_outpc", out_pc, 8'h0A);
    out_ready = 1'b0;
    repeat (2) tick();
    chk("c_stall_outpc", out_pc, 8'h0A);
    jmp_en = 1'b1; jmp_addr = 8'h40;
    tick();
    jmp_en = 1'b0;
    chk("c_flush_valid", out_valid, 0);
`ifdef ECPU_FETCH_CNT_EN
    chk("c_cnt", fetch_cnt, 32'd10);
`endif
    #2 rst = 1'b1;
    #1;
    chk("c_rst_valid", out_valid, 0);
`ifdef ECPU_FETCH_CNT_EN
    chk("c_rst_cnt", fetch_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
